aes_enc_core: RTL and testbench



---
 rtl/aes_enc_core_if.sv | 22 ++
 rtl/aes_enc_core.sv | 117 +++++++++++
 tb/tb_aes_enc_core.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_core_if.sv
// Block and round-key handshake between the AES encrypt core and its neighbours.
// master: front end / key schedule / output formatter side; slave: the core.
interface aes_enc_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  modport master (
    output in_valid, din, rk, out_ready,
    input  in_ready, rk_idx, out_valid, dout
  );

  modport slave (
    input  in_valid, din, rk, out_ready,
    output in_ready, rk_idx, out_valid, dout
  );
endinterface

// File: rtl/aes_enc_core.sv
// aes_enc_core: iterative AES-128 encryptor, initial AddRoundKey then one round per clock.
// Defining AES_ENC_ABORT_EN adds an abort input that cancels a block in RUN or DONE.
//   state | meaning
//   IDLE  | waiting for a plaintext block, rk_idx=0
//   RUN   | applying round round_q with the key fetched at rk_idx=round_q
//   DONE  | ciphertext presented on dout until out_ready
module aes_enc_core (
  input logic clk,
  input logic rst_n,
`ifdef AES_ENC_ABORT_EN
  input logic abort,
`endif
  aes_enc_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t         st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         kill;

`ifdef AES_ENC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*b -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at bits [127-8*(r+4c) -: 8]; forward ShiftRows reads column (c+r) mod 4.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last);
    logic [127:0] t;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      m[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return last ? t : m;
  endfunction

  always_comb begin
    st_d          = st_q;
    state_d       = state_q;
    round_d       = round_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = 4'd0;
    case (st_q)
      IDLE: begin
        bus.in_ready = rst_n;
        if (bus.in_valid && !kill) begin
          state_d = bus.din ^ bus.rk;
          round_d = 4'd1;
          st_d    = RUN;
        end
      end
      RUN: begin
        bus.rk_idx = round_q;
        state_d    = enc_round(state_q, round_q == 4'd10) ^ bus.rk;
        if (round_q == 4'd10) st_d = DONE;
        else                  round_d = round_q + 4'd1;
      end
      DONE: begin
        bus.out_valid = rst_n;
        if (bus.out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // abort outranks both round progress and out_ready
    if (kill && st_q != IDLE) begin
      st_d    = IDLE;
      state_d = state_q;
      round_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign bus.dout = state_q;
endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core: FIPS-197 vectors plus random blocks against a byte-level AES model.
module tb_aes_enc_core;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_out = 0;
  logic [7:0]   sb  [256];
  logic [127:0] rks [16];

  aes_enc_core_if bus ();
`ifdef AES_ENC_ABORT_EN
  logic abort;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.rk = rks[bus.rk_idx];

  aes_enc_core dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_ENC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] av;
    logic [7:0] xv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      av  = a[7:0];
      for (int x = 1; x < 256; x++) begin
        xv = x[7:0];
        if (gmul(av, xv) == 8'h01) inv = xv;
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++)
      rks[j] = (j < 11) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rks[0][127-8*k -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sb[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rks[rnd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called on a falling edge with the core in IDLE; returns on a falling edge back in IDLE.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input int hold,
                           input bit keep_valid, input string tag, output logic [127:0] got);
    logic [127:0] exp_ct;
    int n;
    load_key(key);
    exp_ct = model_enc(pt);
    bus.din       = pt;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({tag, ".accept_ready"}, 128'(bus.in_ready), 128'(1));
    chk({tag, ".rk_idx_T"}, 128'(bus.rk_idx), 128'(0));
    @(negedge clk);
    bus.in_valid = keep_valid;
    bus.din      = rnd128();
    n = 1;
    while (!bus.out_valid && n < 40) begin
      if (n <= 10) chk({tag, ".rk_idx_run"}, 128'(bus.rk_idx), 128'(n));
      @(negedge clk);
      n++;
    end
    last_out = cyc;
    got = bus.dout;
    chk({tag, ".latency"}, 128'(n), 128'(11));
    chk({tag, ".dout_model"}, bus.dout, exp_ct);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_dout"}, bus.dout, exp_ct);
      chk({tag, ".hold_in_ready"}, 128'(bus.in_ready), 128'(0));
      chk({tag, ".hold_out_valid"}, 128'(bus.out_valid), 128'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".after_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, ".after_in_ready"}, 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [127:0] got;
    int c1, n;
    init_sbox();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din       = '0;
`ifdef AES_ENC_ABORT_EN
    abort = 1'b0;
`endif
    load_key(K_B);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst.out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst.dout", bus.dout, 128'h0);
    chk("rst.rk_idx", 128'(bus.rk_idx), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready_after", 128'(bus.in_ready), 128'(1));

    run_block(K_B, PT_B, 0, 1'b0, "appB", got);
    chk("appB.vector", got, CT_B);
    run_block(K_C, PT_C, 0, 1'b0, "appC1", got);
    chk("appC1.vector", got, CT_C);

    run_block(K_C, PT_C, 20, 1'b1, "bp", got);
    chk("bp.vector", got, CT_C);
    run_block(K_B, PT_B, 0, 1'b0, "bp_next", got);
    chk("bp_next.vector", got, CT_B);

    run_block(K_C, PT_C, 0, 1'b0, "b2b_1", got);
    chk("b2b_1.vector", got, CT_C);
    c1 = last_out;
    run_block(K_C, PT_C, 0, 1'b0, "b2b_2", got);
    chk("b2b_2.vector", got, CT_C);
    chk("b2b.spacing", 128'(last_out - c1), 128'(12));

    for (int i = 0; i < 6; i++)
      run_block(rnd128(), rnd128(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand", got);

    // reset during round 5: block dropped, core idle once reset releases
    load_key(K_C);
    bus.din      = PT_C;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mrst.reach_round5", 128'(bus.rk_idx), 128'(5));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.in_ready_low", 128'(bus.in_ready), 128'(0));
    chk("mrst.out_valid_low", 128'(bus.out_valid), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst.in_ready_after", 128'(bus.in_ready), 128'(1));
    for (int i = 0; i < 15; i++) begin
      chk("mrst.no_out_valid", 128'(bus.out_valid), 128'(0));
      @(negedge clk);
    end
    run_block(K_B, PT_B, 1, 1'b0, "mrst_next", got);
    chk("mrst_next.vector", got, CT_B);

`ifdef AES_ENC_ABORT_EN
    // abort in IDLE blocks the accept in that cycle
    load_key(K_C);
    bus.din      = PT_C;
    bus.in_valid = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_idle.rk_idx", 128'(bus.rk_idx), 128'(0));
    chk("abort_idle.in_ready", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx != 4'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort.reach_round3", 128'(bus.rk_idx), 128'(3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort.in_ready_next", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    chk("abort.in_ready_2", 128'(bus.in_ready), 128'(1));
    for (int i = 0; i < 15; i++) begin
      chk("abort.no_out_valid", 128'(bus.out_valid), 128'(0));
      @(negedge clk);
    end
    run_block(K_C, PT_C, 0, 1'b0, "abort_next", got);
    chk("abort_next.vector", got, CT_C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
